// File: rtl/wm_neighbourhood_fetch.sv
// Causal 2x2 neighbourhood fetch for the watermark insertion stage.
// A single-row line buffer supplies the upper/upper-left pixels; border pixels carry no symbol.
module wm_neighbourhood_fetch #(
  parameter int IMG_WIDTH  = 4,
  parameter int IMG_HEIGHT = 3,
  parameter int WM_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  input  logic       pix_sof,
  output logic       pix_ready,
  input  logic [1:0] wm_sym,
  input  logic       wm_valid,
  output logic       wm_ready,
  output logic [7:0] Data1,
  output logic [7:0] Data2,
  output logic [7:0] Data3,
  output logic [7:0] Data4,
  output logic [1:0] WM_data,
  output logic       start,
  output logic       frame_done
);

  localparam int CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int WCW = $clog2(WM_LEN + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [WCW-1:0] wm_cnt_q, wm_cnt_d;
  logic [7:0]     left_q, left_d, ul_q, ul_d;
  logic [7:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic [1:0]     wm_q, wm_d;
  logic           start_q, start_d, fd_q, fd_d;
  logic [7:0]     line_buf_q [IMG_WIDTH];

  logic           sof_s, interior_s, need_wm_s, accept_s, process_s, last_s;
  logic [RW-1:0]  cur_row_s;
  logic [CW-1:0]  cur_col_s;
  logic [WCW-1:0] cur_cnt_s;

  // An accepted sof forces position (0,0) and a fresh symbol count for this very pixel.
  assign sof_s      = pix_valid & pix_sof;
  assign cur_row_s  = sof_s ? {RW{1'b0}}  : row_q;
  assign cur_col_s  = sof_s ? {CW{1'b0}}  : col_q;
  assign cur_cnt_s  = sof_s ? {WCW{1'b0}} : wm_cnt_q;
  assign interior_s = (cur_row_s != {RW{1'b0}}) & (cur_col_s != {CW{1'b0}});
  assign need_wm_s  = interior_s & (cur_cnt_s < WCW'(WM_LEN));
  assign pix_ready  = ~need_wm_s | wm_valid;
  assign wm_ready   = pix_valid & pix_ready & need_wm_s;
  assign accept_s   = pix_valid & pix_ready;
  assign process_s  = accept_s & ((state_q == RUN) | sof_s);
  assign last_s     = (cur_row_s == RW'(IMG_HEIGHT - 1)) & (cur_col_s == CW'(IMG_WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    wm_cnt_d = wm_cnt_q;
    left_d   = left_q;
    ul_d     = ul_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    d4_d     = d4_q;
    wm_d     = wm_q;
    start_d  = 1'b0;
    fd_d     = 1'b0;
    if (process_s) begin
      d1_d     = pix_data;
      d2_d     = interior_s ? left_q : 8'h00;
      d3_d     = interior_s ? ul_q : 8'h00;
      d4_d     = interior_s ? line_buf_q[cur_col_s] : 8'h00;
      // Illegal symbol 11 is consumed but embeds nothing.
      wm_d     = (need_wm_s && (wm_sym != 2'b11)) ? wm_sym : 2'b00;
      start_d  = 1'b1;
      fd_d     = last_s;
      left_d   = pix_data;
      ul_d     = line_buf_q[cur_col_s];
      wm_cnt_d = need_wm_s ? (cur_cnt_s + WCW'(1)) : cur_cnt_s;
      if (last_s) begin
        state_d  = IDLE;
        row_d    = {RW{1'b0}};
        col_d    = {CW{1'b0}};
        wm_cnt_d = {WCW{1'b0}};
      end else if (cur_col_s == CW'(IMG_WIDTH - 1)) begin
        state_d = RUN;
        col_d   = {CW{1'b0}};
        row_d   = cur_row_s + RW'(1);
      end else begin
        state_d = RUN;
        col_d   = cur_col_s + CW'(1);
        row_d   = cur_row_s;
      end
    end else begin
      start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= {RW{1'b0}};
      col_q    <= {CW{1'b0}};
      wm_cnt_q <= {WCW{1'b0}};
      left_q   <= 8'h00;
      ul_q     <= 8'h00;
      d1_q     <= 8'h00;
      d2_q     <= 8'h00;
      d3_q     <= 8'h00;
      d4_q     <= 8'h00;
      wm_q     <= 2'b00;
      start_q  <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wm_cnt_q <= wm_cnt_d;
      left_q   <= left_d;
      ul_q     <= ul_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      d4_q     <= d4_d;
      wm_q     <= wm_d;
      start_q  <= start_d;
      fd_q     <= fd_d;
    end
  end

  // Line buffer holds the previous row; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && process_s) begin
      line_buf_q[cur_col_s] <= pix_data;
    end
  end

  assign Data1      = d1_q;
  assign Data2      = d2_q;
  assign Data3      = d3_q;
  assign Data4      = d4_q;
  assign WM_data    = wm_q;
  assign start      = start_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_wm_neighbourhood_fetch.sv
// Randomized and directed bench for wm_neighbourhood_fetch against a frame-array reference model.
module tb_wm_neighbourhood_fetch;
  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst, pix_valid, pix_sof, wm_valid;
  logic [7:0] pix_data;
  logic [1:0] wm_sym;
  logic       pix_ready, wm_ready, start, frame_done;
  logic [7:0] Data1, Data2, Data3, Data4;
  logic [1:0] WM_data;

  always #5 clk = ~clk;

  wm_neighbourhood_fetch #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .WM_LEN(L)) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .wm_sym(wm_sym), .wm_valid(wm_valid), .wm_ready(wm_ready),
    .Data1(Data1), .Data2(Data2), .Data3(Data3), .Data4(Data4), .WM_data(WM_data),
    .start(start), .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int start_seen = 0;

  // Reference model: whole-frame pixel array indexed by (row, col).
  logic [7:0] img [H][W];
  int         m_r = 0, m_c = 0, m_wc = 0;
  bit         m_idle = 1'b1;
  bit         m_acc, m_wmr;
  logic [7:0] e_d1 = 8'h00, e_d2 = 8'h00, e_d3 = 8'h00, e_d4 = 8'h00;
  logic [1:0] e_wm = 2'b00;
  logic       e_start = 1'b0, e_fd = 1'b0;
  logic [1:0] syms [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic pv, input logic ps, input logic [7:0] pd,
                      input logic wv, input logic [1:0] ws);
    int  r_, c_, wc_;
    bit  sof, intr, need, rdy, proc, last;
    rst = r; pix_valid = pv; pix_sof = ps; pix_data = pd; wm_valid = wv; wm_sym = ws;
    sof  = pv && ps;
    r_   = sof ? 0 : m_r;
    c_   = sof ? 0 : m_c;
    wc_  = sof ? 0 : m_wc;
    intr = (r_ > 0) && (c_ > 0);
    need = intr && (wc_ < L);
    rdy  = !need || wv;
    m_acc = !r && pv && rdy;
    m_wmr = !r && pv && rdy && need;
    proc  = m_acc && (!m_idle || sof);
    @(negedge clk);
    if (!r) begin
      chk("pix_ready", pix_ready, rdy);
      chk("wm_ready", wm_ready, m_wmr);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_idle = 1'b1; m_r = 0; m_c = 0; m_wc = 0;
      e_d1 = 8'h00; e_d2 = 8'h00; e_d3 = 8'h00; e_d4 = 8'h00; e_wm = 2'b00;
      e_start = 1'b0; e_fd = 1'b0;
    end else begin
      e_start = proc;
      e_fd    = 1'b0;
      if (proc) begin
        e_d1 = pd;
        if (intr) begin
          e_d2 = img[r_][c_-1];
          e_d3 = img[r_-1][c_-1];
          e_d4 = img[r_-1][c_];
        end else begin
          e_d2 = 8'h00; e_d3 = 8'h00; e_d4 = 8'h00;
        end
        e_wm = (need && ws != 2'b11) ? ws : 2'b00;
        img[r_][c_] = pd;
        last = (r_ == H - 1) && (c_ == W - 1);
        e_fd = last;
        if (need) wc_++;
        if (last) begin
          m_idle = 1'b1; m_r = 0; m_c = 0; m_wc = 0;
        end else begin
          m_idle = 1'b0;
          c_++;
          if (c_ == W) begin c_ = 0; r_++; end
          m_r = r_; m_c = c_; m_wc = wc_;
        end
      end
    end
    chk("start", start, e_start);
    chk("frame_done", frame_done, e_fd);
    chk("Data1", Data1, e_d1);
    chk("Data2", Data2, e_d2);
    chk("Data3", Data3, e_d3);
    chk("Data4", Data4, e_d4);
    chk("WM_data", WM_data, e_wm);
    if (start === 1'b1) start_seen++;
  endtask

  // Offer one pixel until accepted; symbol stream comes from syms, wm_valid held low for 'stall' cycles.
  task automatic send(input logic [7:0] pd, input bit sof, input int stall);
    logic [1:0] ws;
    for (int k = 0; k < 20; k++) begin
      ws = (syms.size() > 0) ? syms[0] : 2'b00;
      step(1'b0, 1'b1, sof, pd, (k >= stall), ws);
      if (m_wmr && syms.size() > 0) void'(syms.pop_front());
      if (m_acc) return;
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00; wm_valid = 1'b0; wm_sym = 2'b00;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 2'b01);
    step(1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 2'b10);

    // Full frame with symbols 01,10,00,01
    start_seen = 0;
    syms = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int p = 1; p <= 12; p++) begin
      send(8'(p), (p == 1), 0);
      if (p == 6) begin
        chk("p6_d1", Data1, 32'd6); chk("p6_d2", Data2, 32'd5);
        chk("p6_d3", Data3, 32'd1); chk("p6_d4", Data4, 32'd2); chk("p6_wm", WM_data, 32'd1);
      end
      if (p == 7) chk("p7_wm", WM_data, 32'd2);
      if (p == 10) begin
        chk("p10_d2", Data2, 32'd9); chk("p10_d3", Data3, 32'd5);
        chk("p10_d4", Data4, 32'd6); chk("p10_wm", WM_data, 32'd1);
      end
      if (p == 12) chk("p12_fd", frame_done, 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b00);
    chk("start_cnt", start_seen, 32'd12);

    // Stall on pixel 7
    syms = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int p = 1; p <= 12; p++) begin
      send(8'(p), (p == 1), (p == 7) ? 3 : 0);
      if (p == 7) chk("stall_p7_wm", WM_data, 32'd2);
    end

    // Dropped pixels in IDLE, then sof restart mid-frame
    send(8'h55, 1'b0, 0);
    chk("drop_start", start, 32'd0);
    send(8'h66, 1'b0, 0);
    syms = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int p = 1; p <= 7; p++) send(8'(p), (p == 1), 0);
    syms = '{2'b10, 2'b01, 2'b01, 2'b10};
    send(8'd8, 1'b1, 0);
    chk("restart_d2", Data2, 32'd0);
    chk("restart_wm", WM_data, 32'd0);
    for (int p = 9; p <= 19; p++) begin
      send(8'(p), 1'b0, 0);
      if (p == 13) chk("restart_p13_wm", WM_data, 32'd2);
    end

    // Reset mid-frame after pixel 7, then fresh frame 21..32
    syms = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int p = 1; p <= 7; p++) send(8'(p), (p == 1), 0);
    step(1'b1, 1'b1, 1'b0, 8'd8, 1'b1, 2'b01);
    syms = '{2'b10, 2'b01, 2'b00, 2'b01};
    for (int p = 21; p <= 32; p++) begin
      send(8'(p), (p == 21), 0);
      if (p == 26) begin
        chk("p26_d2", Data2, 32'd25); chk("p26_d3", Data3, 32'd21);
        chk("p26_d4", Data4, 32'd22); chk("p26_wm", WM_data, 32'd2);
      end
    end

    // Randomized traffic including illegal symbols and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           8'($urandom), ($urandom_range(0, 2) != 0), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
